// File: rtl/controle_nivel_auto.sv
`default_nettype none
// ============================================================================
// Module      : controle_nivel_auto
// Description : Automatic-mode tank level controller. Debounces the low and
//               high level sensors, runs the fill cycle and issues one-cycle
//               open/close command pulses to the valve block. Includes fill
//               timeout detection and a minimum closed interval after a
//               normal fill stop.
// Revision    : 1.0 - initial release
// ============================================================================
module controle_nivel_auto #(
  parameter int DEBOUNCE = 4,     // consecutive differing samples before filtered value changes
  parameter int T_ENCHER = 1000,  // maximum cycles in ENCHENDO before timeout
  parameter int T_ESPERA = 50,    // cycles held in ESPERA after a normal stop
  parameter int CW       = 16     // shared timer width
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       habilita,
  input  logic       sensor_baixo,
  input  logic       sensor_alto,
  output logic       abre_auto,
  output logic       fecha_auto,
  output logic       enchendo,
  output logic       erro,
  output logic [1:0] estado
);

  // Debounce counter width: it only needs to count up to DEBOUNCE-1.
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [DW-1:0] C_DEB_LAST    = DW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] C_ENCHER_LAST = CW'(T_ENCHER - 1);
  localparam logic [CW-1:0] C_ESPERA_LAST = CW'(T_ESPERA - 1);

  typedef enum logic [1:0] {
    REPOUSO  = 2'd0,
    ENCHENDO = 2'd1,
    ESPERA   = 2'd2,
    ERRO     = 2'd3
  } estado_t;

  // --------------------------------------------------------------------------
  // Sensor debounce
  // --------------------------------------------------------------------------
  logic          baixo_f_q, baixo_f_d;
  logic          alto_f_q,  alto_f_d;
  logic [DW-1:0] baixo_cnt_q, baixo_cnt_d;
  logic [DW-1:0] alto_cnt_q,  alto_cnt_d;

  // Next filtered value: adopt the raw value once it has disagreed for DEBOUNCE samples.
  always_comb begin
    baixo_f_d   = baixo_f_q;
    baixo_cnt_d = '0;
    if (sensor_baixo != baixo_f_q) begin
      if (baixo_cnt_q == C_DEB_LAST) begin
        baixo_f_d   = sensor_baixo;
        baixo_cnt_d = '0;
      end else begin
        baixo_cnt_d = baixo_cnt_q + 1'b1;
      end
    end

    alto_f_d   = alto_f_q;
    alto_cnt_d = '0;
    if (sensor_alto != alto_f_q) begin
      if (alto_cnt_q == C_DEB_LAST) begin
        alto_f_d   = sensor_alto;
        alto_cnt_d = '0;
      end else begin
        alto_cnt_d = alto_cnt_q + 1'b1;
      end
    end
  end

  // Debounce registers; low sensor resets "wet" so a fill never starts straight out of reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      baixo_f_q   <= 1'b1;
      alto_f_q    <= 1'b0;
      baixo_cnt_q <= '0;
      alto_cnt_q  <= '0;
    end else begin
      baixo_f_q   <= baixo_f_d;
      alto_f_q    <= alto_f_d;
      baixo_cnt_q <= baixo_cnt_d;
      alto_cnt_q  <= alto_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Fill cycle state machine
  // --------------------------------------------------------------------------
  estado_t       state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          abre_q,  abre_d;
  logic          fecha_q, fecha_d;
  logic          enchendo_q;
  logic          erro_q;
  logic [1:0]    estado_q;

  // Next state, timer and command pulses; checks in each state are in priority order.
  always_comb begin
    state_d = state_q;
    timer_d = '0;
    abre_d  = 1'b0;
    fecha_d = 1'b0;

    unique case (state_q)
      REPOUSO: begin
        if (!habilita) begin
          state_d = REPOUSO;
        end else if (!baixo_f_q && alto_f_q) begin
          // High wet while low dry cannot be real: close and latch the fault.
          state_d = ERRO;
          fecha_d = 1'b1;
        end else if (!baixo_f_q && !alto_f_q) begin
          state_d = ENCHENDO;
          abre_d  = 1'b1;
        end
      end

      ENCHENDO: begin
        if (!habilita) begin
          state_d = REPOUSO;
          fecha_d = 1'b1;
        end else if (alto_f_q) begin
          // Checked before the timeout so a simultaneous rise is a normal stop.
          state_d = ESPERA;
          fecha_d = 1'b1;
        end else if (timer_q == C_ENCHER_LAST) begin
          state_d = ERRO;
          fecha_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ESPERA: begin
        // Valve is already closed here, so leaving needs no command.
        if (!habilita) begin
          state_d = REPOUSO;
        end else if (timer_q == C_ESPERA_LAST) begin
          state_d = REPOUSO;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      ERRO: begin
        // Sticky until the operator takes manual control.
        if (!habilita) begin
          state_d = REPOUSO;
        end
      end

      default: begin
        state_d = REPOUSO;
      end
    endcase
  end

  // State, timer and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= REPOUSO;
      timer_q    <= '0;
      abre_q     <= 1'b0;
      fecha_q    <= 1'b0;
      enchendo_q <= 1'b0;
      erro_q     <= 1'b0;
      estado_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      abre_q     <= abre_d;
      fecha_q    <= fecha_d;
      enchendo_q <= (state_d == ENCHENDO);
      erro_q     <= (state_d == ERRO);
      estado_q   <= state_d;
    end
  end

  assign abre_auto  = abre_q;
  assign fecha_auto = fecha_q;
  assign enchendo   = enchendo_q;
  assign erro       = erro_q;
  assign estado     = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_nivel_auto.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_nivel_auto
// Description : Directed self-checking bench for controle_nivel_auto with
//               DEBOUNCE=4, T_ENCHER=20, T_ESPERA=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_nivel_auto;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       habilita;
  logic       sensor_baixo;
  logic       sensor_alto;
  logic       abre_auto;
  logic       fecha_auto;
  logic       enchendo;
  logic       erro;
  logic [1:0] estado;

  int n_checks = 0;
  int n_fails  = 0;

  logic [5:0] w_obs;
  assign w_obs = {abre_auto, fecha_auto, enchendo, erro, estado};

  always #5 clock = ~clock;

  controle_nivel_auto #(
    .DEBOUNCE (4),
    .T_ENCHER (20),
    .T_ESPERA (8),
    .CW       (16)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .habilita     (habilita),
    .sensor_baixo (sensor_baixo),
    .sensor_alto  (sensor_alto),
    .abre_auto    (abre_auto),
    .fecha_auto   (fecha_auto),
    .enchendo     (enchendo),
    .erro         (erro),
    .estado       (estado)
  );

  // Expected output vector {abre, fecha, enchendo, erro, estado}.
  function automatic logic [5:0] exp_out(input bit a, input bit f, input bit e,
                                         input bit r, input logic [1:0] s);
    return {a, f, e, r, s};
  endfunction

  task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed {abre,fecha,ench,erro,estado}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; habilita = 1'b1; sensor_baixo = 1'b0; sensor_alto = 1'b0;
    tick(1); check_eq("rst_a", w_obs, 6'd0);
    tick(1); check_eq("rst_b", w_obs, 6'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1); check_eq("deb_baixo", w_obs, 6'd0);
    end
    tick(1); check_eq("abre_start", w_obs, exp_out(1, 0, 1, 0, 2'd1));
    tick(1); check_eq("abre_1cyc", w_obs, exp_out(0, 0, 1, 0, 2'd1));

    // Normal fill: alto raised at timer = 10
    tick(9);
    sensor_alto = 1'b1;
    tick(4); check_eq("alto_deb", w_obs, exp_out(0, 0, 1, 0, 2'd1));
    tick(1); check_eq("fecha_stop", w_obs, exp_out(0, 1, 0, 0, 2'd2));
    tick(7); check_eq("espera_hold", w_obs, exp_out(0, 0, 0, 0, 2'd2));
    tick(1); check_eq("espera_end", w_obs, 6'd0);
    // Sensors stay baixo=0/alto=1: inconsistent in REPOUSO
    tick(1); check_eq("incons_erro", w_obs, exp_out(0, 1, 0, 1, 2'd3));
    tick(3); check_eq("erro_sticky", w_obs, exp_out(0, 0, 0, 1, 2'd3));
    habilita = 1'b0; sensor_alto = 1'b0;
    tick(1); check_eq("erro_clear", w_obs, 6'd0);
    tick(6); check_eq("no_abre_manual", w_obs, 6'd0);
    habilita = 1'b1;
    tick(1); check_eq("refill", w_obs, exp_out(1, 0, 1, 0, 2'd1));

    // Debounce rejection: 3-cycle glitch, then 4-cycle pulse
    tick(1);
    sensor_alto = 1'b1; tick(3); sensor_alto = 1'b0;
    tick(2); check_eq("glitch3", w_obs, exp_out(0, 0, 1, 0, 2'd1));
    tick(1);
    sensor_alto = 1'b1; tick(4); sensor_alto = 1'b0;
    check_eq("pulse4_deb", w_obs, exp_out(0, 0, 1, 0, 2'd1));
    tick(1); check_eq("pulse4_stop", w_obs, exp_out(0, 1, 0, 0, 2'd2));
    tick(8); check_eq("espera_to_repouso", w_obs, 6'd0);
    tick(1); check_eq("refill_after_espera", w_obs, exp_out(1, 0, 1, 0, 2'd1));

    // Timeout: 20 cycles after entry
    tick(19); check_eq("pre_timeout", w_obs, exp_out(0, 0, 1, 0, 2'd1));
    tick(1);  check_eq("timeout", w_obs, exp_out(0, 1, 0, 1, 2'd3));
    tick(4);  check_eq("timeout_sticky", w_obs, exp_out(0, 0, 0, 1, 2'd3));
    habilita = 1'b0;
    tick(1);  check_eq("timeout_clear", w_obs, 6'd0);

    // Manual takeover at timer = 5
    habilita = 1'b1;
    tick(1); check_eq("manual_fill", w_obs, exp_out(1, 0, 1, 0, 2'd1));
    tick(5); habilita = 1'b0;
    tick(1); check_eq("manual_stop", w_obs, exp_out(0, 1, 0, 0, 2'd0));
    tick(1); check_eq("manual_1cyc", w_obs, 6'd0);
    tick(3); check_eq("manual_idle", w_obs, 6'd0);

    // Timeout and alto_f rise on the same edge
    habilita = 1'b1;
    tick(1);  check_eq("race_fill", w_obs, exp_out(1, 0, 1, 0, 2'd1));
    tick(15); sensor_alto = 1'b1;
    tick(4);  check_eq("race_pre", w_obs, exp_out(0, 0, 1, 0, 2'd1));
    tick(1);  check_eq("race_espera", w_obs, exp_out(0, 1, 0, 0, 2'd2));
    habilita = 1'b0; sensor_alto = 1'b0;
    tick(1);  check_eq("espera_manual", w_obs, 6'd0);
    tick(4);

    // Reset mid-fill at timer = 7
    habilita = 1'b1;
    tick(1); check_eq("fill6", w_obs, exp_out(1, 0, 1, 0, 2'd1));
    tick(7); reset_n = 1'b0;
    tick(1); check_eq("rst_midfill", w_obs, 6'd0);
    tick(1); check_eq("rst_hold", w_obs, 6'd0);
    reset_n = 1'b1;
    tick(4); check_eq("post_rst_deb", w_obs, 6'd0);
    tick(1); check_eq("post_rst_abre", w_obs, exp_out(1, 0, 1, 0, 2'd1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
